// File: rtl/pulse_event_batcher_if.sv
// -----------------------------------------------------------------------------
// pulse_event_batcher_if
// Batch-report channel between pulse_event_batcher and its consumer.
//
//   evt_valid   producer -> consumer  batch available
//   evt_ready   consumer -> producer  consumer accepts batch
//   evt_count   producer -> consumer  pulses in batch (CNT_W bits)
//   evt_reason  producer -> consumer  00 threshold, 01 timeout, 10 flush
//   evt_sat     producer -> consumer  count saturated, value is a lower bound
//
// master: the batcher (drives the batch); slave: downstream consumer.
// -----------------------------------------------------------------------------
interface pulse_event_batcher_if #(
    parameter int CNT_W = 8
);
    logic             evt_valid;
    logic             evt_ready;
    logic [CNT_W-1:0] evt_count;
    logic [1:0]       evt_reason;
    logic             evt_sat;

    modport master (
        output evt_valid,
        output evt_count,
        output evt_reason,
        output evt_sat,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_count,
        input  evt_reason,
        input  evt_sat,
        output evt_ready
    );
endinterface

// File: rtl/pulse_event_batcher.sv
// -----------------------------------------------------------------------------
// pulse_event_batcher
// Counts single-cycle synchronized event pulses into batches and presents each
// closed batch (count + reason + saturation flag) on a valid/ready channel.
// Pulses arriving while a batch waits for acceptance are held in a pending
// counter and carried into the next batch, so no pulse is ever dropped
// (short of counter saturation, which is flagged).
//
// Ports:
//   clk_dst   in   destination-domain clock
//   rst       in   asynchronous reset, active-high
//   pulse_in  in   one-cycle event pulse, at most one per cycle
//   flush     in   force-close an open batch (ignored when idle or reporting)
//   evt       if   batch channel (master side): evt_valid/ready/count/reason/sat
//   busy      out  high whenever the batcher is not idle
// -----------------------------------------------------------------------------
module pulse_event_batcher #(
    parameter int CNT_W   = 8,
    parameter int THRESH  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                          clk_dst,
    input  logic                          rst,
    input  logic                          pulse_in,
    input  logic                          flush,
    pulse_event_batcher_if.master         evt,
    output logic                          busy
);

    localparam int TMO_W = $clog2(TIMEOUT);

    localparam logic [1:0] REASON_THRESH  = 2'b00;
    localparam logic [1:0] REASON_TIMEOUT = 2'b01;
    localparam logic [1:0] REASON_FLUSH   = 2'b10;

    localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(THRESH);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] acc_reg, acc_next;
    logic             sat_acc_reg, sat_acc_next;
    logic [CNT_W-1:0] pend_reg, pend_next;
    logic             sat_pend_reg, sat_pend_next;
    logic [TMO_W-1:0] timer_reg, timer_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [1:0]       reason_reg, reason_next;
    logic             sat_reg, sat_next;

    // Saturating increment: returns {increment_lost, new_value}.
    function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] v,
                                               input logic             inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, v} + {{CNT_W{1'b0}}, inc};
        if (sum[CNT_W]) begin
            sum = {1'b1, {CNT_W{1'b1}}};
        end
        return sum;
    endfunction

    logic [CNT_W-1:0] acc_inc, pend_inc;
    logic             acc_lost, pend_lost;
    logic [TMO_W-1:0] timer_inc;

    assign {acc_lost, acc_inc}   = sat_add(acc_reg, pulse_in);
    assign {pend_lost, pend_inc} = sat_add(pend_reg, pulse_in);
    assign timer_inc             = timer_reg + 1'b1;

    always_ff @(posedge clk_dst or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            acc_reg      <= '0;
            sat_acc_reg  <= 1'b0;
            pend_reg     <= '0;
            sat_pend_reg <= 1'b0;
            timer_reg    <= '0;
            count_reg    <= '0;
            reason_reg   <= REASON_THRESH;
            sat_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            acc_reg      <= acc_next;
            sat_acc_reg  <= sat_acc_next;
            pend_reg     <= pend_next;
            sat_pend_reg <= sat_pend_next;
            timer_reg    <= timer_next;
            count_reg    <= count_next;
            reason_reg   <= reason_next;
            sat_reg      <= sat_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        acc_next      = acc_reg;
        sat_acc_next  = sat_acc_reg;
        pend_next     = pend_reg;
        sat_pend_next = sat_pend_reg;
        timer_next    = timer_reg;
        count_next    = count_reg;
        reason_next   = reason_reg;
        sat_next      = sat_reg;

        case (state_reg)
            IDLE: begin
                if (pulse_in) begin
                    acc_next     = CNT_W'(1);
                    sat_acc_next = 1'b0;
                    timer_next   = '0;
                    if (THRESH == 1) begin
                        // A single pulse already fills the batch.
                        state_next  = REPORT;
                        count_next  = CNT_W'(1);
                        reason_next = REASON_THRESH;
                        sat_next    = 1'b0;
                    end else begin
                        state_next = ACCUM;
                    end
                end
            end

            ACCUM: begin
                acc_next     = acc_inc;
                sat_acc_next = sat_acc_reg | acc_lost;
                timer_next   = timer_inc;
                // Closing count includes this cycle's pulse.
                count_next   = acc_inc;
                sat_next     = sat_acc_reg | acc_lost;
                if (acc_inc >= THRESH_C) begin
                    state_next  = REPORT;
                    reason_next = REASON_THRESH;
                end else if (flush) begin
                    state_next  = REPORT;
                    reason_next = REASON_FLUSH;
                end else if (timer_inc == TMO_LAST) begin
                    // Compared on the incremented value so that the opening
                    // cycle counts as cycle 0 of the batch: the timeout batch
                    // becomes valid exactly TIMEOUT cycles after it opened.
                    state_next  = REPORT;
                    reason_next = REASON_TIMEOUT;
                end else begin
                    count_next = count_reg;
                    sat_next   = sat_reg;
                end
            end

            REPORT: begin
                pend_next     = pend_inc;
                sat_pend_next = sat_pend_reg | pend_lost;
                if (evt.evt_ready) begin
                    pend_next     = '0;
                    sat_pend_next = 1'b0;
                    if (pend_inc == '0) begin
                        state_next = IDLE;
                    end else begin
                        // Carry held pulses (plus this cycle's) into a new
                        // batch without passing through IDLE.
                        acc_next     = pend_inc;
                        sat_acc_next = sat_pend_reg | pend_lost;
                        timer_next   = '0;
                        state_next   = ACCUM;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // All outputs come straight from registers, so the async reset clears
    // them without waiting for a clock edge.
    assign evt.evt_valid  = (state_reg == REPORT);
    assign evt.evt_count  = count_reg;
    assign evt.evt_reason = reason_reg;
    assign evt.evt_sat    = sat_reg;
    assign busy           = (state_reg != IDLE);

endmodule
